// File: rtl/cpu_bus_bridge.sv
// cpu_bus_bridge: serialises the core's fetch and data-memory ports onto a
// single request/response bus with one transaction outstanding. The data
// access always goes first, then the fetch. stall_o holds the core until both
// accesses of the current core cycle have finished.
module cpu_bus_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  // core fetch port
  input  logic                inst_ce_i,
  input  logic [ADDR_W-1:0]   inst_addr_i,
  output logic [DATA_W-1:0]   inst_rdata_o,
  // core data port
  input  logic                data_ce_i,
  input  logic                data_we_i,
  input  logic [DATA_W/8-1:0] data_sel_i,
  input  logic [ADDR_W-1:0]   data_addr_i,
  input  logic [DATA_W-1:0]   data_wdata_i,
  output logic [DATA_W-1:0]   data_rdata_o,
  output logic                stall_o,
  // external bus
  output logic                bus_req_o,
  output logic                bus_we_o,
  output logic [DATA_W/8-1:0] bus_sel_o,
  output logic [ADDR_W-1:0]   bus_addr_o,
  output logic [DATA_W-1:0]   bus_wdata_o,
  input  logic                bus_addr_ok_i,
  input  logic [DATA_W-1:0]   bus_rdata_i,
  input  logic                bus_data_ok_i
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    D_REQ  = 3'd1,
    D_WAIT = 3'd2,
    I_REQ  = 3'd3,
    I_WAIT = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [DATA_W-1:0]   r_inst_rdata;
  logic [DATA_W-1:0]   r_data_rdata;

  // State register; reset returns to IDLE at once, which drops bus_req_o.
  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // Next-state logic: data access before fetch, unbounded waits on the bus.
  // NOTE: a default assignment at the top of each always_comb guarantees no
  // path leaves a variable unassigned, so no latch is inferred.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (data_ce_i)      w_next = D_REQ;
        else if (inst_ce_i) w_next = I_REQ;
      end
      D_REQ:  if (bus_addr_ok_i) w_next = D_WAIT;
      D_WAIT: if (bus_data_ok_i) w_next = inst_ce_i ? I_REQ : DONE;
      I_REQ:  if (bus_addr_ok_i) w_next = I_WAIT;
      I_WAIT: if (bus_data_ok_i) w_next = DONE;
      DONE:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Bus outputs: driven straight from the core ports, which the core holds
  // stable while stalled, so they stay constant until addr_ok arrives.
  always_comb begin
    bus_req_o   = 1'b0;
    bus_we_o    = 1'b0;
    bus_sel_o   = '0;
    bus_addr_o  = '0;
    bus_wdata_o = '0;
    case (r_state)
      D_REQ: begin
        bus_req_o   = 1'b1;
        bus_we_o    = data_we_i;
        bus_sel_o   = data_sel_i;
        bus_addr_o  = data_addr_i;
        bus_wdata_o = data_wdata_i;
      end
      I_REQ: begin
        bus_req_o   = 1'b1;
        bus_sel_o   = '1;
        bus_addr_o  = inst_addr_i;
      end
      default: ;
    endcase
  end

  // Capture read data; data_ok only counts in the two WAIT states, and a
  // store never overwrites the last load value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_inst_rdata <= '0;
      r_data_rdata <= '0;
    end else if (bus_data_ok_i) begin
      if (r_state == D_WAIT && !data_we_i) r_data_rdata <= bus_rdata_i;
      if (r_state == I_WAIT)               r_inst_rdata <= bus_rdata_i;
    end
  end

  assign inst_rdata_o = r_inst_rdata;
  assign data_rdata_o = r_data_rdata;

  // The core is released only in DONE, or when it requests nothing.
  assign stall_o = (r_state != DONE) && (inst_ce_i || data_ce_i);

endmodule

// File: tb/tb_cpu_bus_bridge.sv
// tb_cpu_bus_bridge: drives core transactions with randomised bus latencies
// and checks the bus requests, stall pattern and returned data against a
// transaction-level model of the bridge.
module tb_cpu_bus_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        inst_ce_i = 1'b0;
  logic [31:0] inst_addr_i = '0;
  logic [31:0] inst_rdata_o;
  logic        data_ce_i = 1'b0;
  logic        data_we_i = 1'b0;
  logic [3:0]  data_sel_i = '0;
  logic [31:0] data_addr_i = '0;
  logic [31:0] data_wdata_i = '0;
  logic [31:0] data_rdata_o;
  logic        stall_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic        bus_addr_ok_i = 1'b0;
  logic [31:0] bus_rdata_i = '0;
  logic        bus_data_ok_i = 1'b0;

  int errors = 0;
  int checks = 0;

  // Model state: last values the core should see on its read ports.
  logic [31:0] exp_inst = '0;
  logic [31:0] exp_data = '0;

  typedef struct packed {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        is_inst;
    logic [31:0] resp;
  } acc_t;

  cpu_bus_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .inst_ce_i     (inst_ce_i),
    .inst_addr_i   (inst_addr_i),
    .inst_rdata_o  (inst_rdata_o),
    .data_ce_i     (data_ce_i),
    .data_we_i     (data_we_i),
    .data_sel_i    (data_sel_i),
    .data_addr_i   (data_addr_i),
    .data_wdata_i  (data_wdata_i),
    .data_rdata_o  (data_rdata_o),
    .stall_o       (stall_o),
    .bus_req_o     (bus_req_o),
    .bus_we_o      (bus_we_o),
    .bus_sel_o     (bus_sel_o),
    .bus_addr_o    (bus_addr_o),
    .bus_wdata_o   (bus_wdata_o),
    .bus_addr_ok_i (bus_addr_ok_i),
    .bus_rdata_i   (bus_rdata_i),
    .bus_data_ok_i (bus_data_ok_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Drive a stray data_ok pulse with junk data in a state where it must be ignored.
  task automatic junk_data_ok();
    bus_data_ok_i = 1'($urandom % 2);
    bus_rdata_i   = $urandom;
  endtask

  // One core cycle: called just after the edge that enters IDLE. The model
  // lists the bus accesses in order (data first, then fetch); each request is
  // held for a_dly refused cycles, each response arrives after d_dly cycles.
  task automatic run_txn(input logic dce, input logic dwe, input logic [3:0] dsel,
                         input logic [31:0] daddr, input logic [31:0] dwdata,
                         input logic ice, input logic [31:0] iaddr,
                         input int a_dly, input int d_dly,
                         input logic [31:0] resp_d, input logic [31:0] resp_i);
    acc_t accs[2];
    int   n = 0;
    data_ce_i    = dce;
    data_we_i    = dwe;
    data_sel_i   = dsel;
    data_addr_i  = daddr;
    data_wdata_i = dwdata;
    inst_ce_i    = ice;
    inst_addr_i  = iaddr;
    if (dce) begin
      accs[n] = '{we: dwe, sel: dsel, addr: daddr, wdata: dwdata, is_inst: 1'b0, resp: resp_d};
      n++;
    end
    if (ice) begin
      accs[n] = '{we: 1'b0, sel: 4'hF, addr: iaddr, wdata: 32'h0, is_inst: 1'b1, resp: resp_i};
      n++;
    end

    // IDLE cycle: request pending, nothing on the bus yet.
    @(negedge clk);
    check("idle_stall", 32'(stall_o), 32'(1));
    check("idle_req", 32'(bus_req_o), 32'(0));
    junk_data_ok();
    @(posedge clk);

    for (int k = 0; k < n; k++) begin
      for (int i = 0; i <= a_dly; i++) begin
        @(negedge clk);
        check("req_valid", 32'(bus_req_o), 32'(1));
        check("req_we", 32'(bus_we_o), 32'(accs[k].we));
        check("req_sel", 32'(bus_sel_o), 32'(accs[k].sel));
        check("req_addr", bus_addr_o, accs[k].addr);
        check("req_wdata", bus_wdata_o, accs[k].wdata);
        check("req_stall", 32'(stall_o), 32'(1));
        bus_addr_ok_i = (i == a_dly);
        junk_data_ok();
        @(posedge clk);
      end
      for (int j = 0; j <= d_dly; j++) begin
        @(negedge clk);
        bus_addr_ok_i = 1'b0;
        check("wait_req", 32'(bus_req_o), 32'(0));
        check("wait_stall", 32'(stall_o), 32'(1));
        bus_data_ok_i = (j == d_dly);
        bus_rdata_i   = (j == d_dly) ? accs[k].resp : $urandom;
        @(posedge clk);
      end
      if (accs[k].is_inst)  exp_inst = accs[k].resp;
      else if (!accs[k].we) exp_data = accs[k].resp;
    end

    // DONE cycle: core released, results visible.
    @(negedge clk);
    check("done_stall", 32'(stall_o), 32'(0));
    check("done_req", 32'(bus_req_o), 32'(0));
    check("done_inst", inst_rdata_o, exp_inst);
    check("done_data", data_rdata_o, exp_data);
    junk_data_ok();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state, before any clock edge.
    #1;
    check("rst_req", 32'(bus_req_o), 32'(0));
    check("rst_we", 32'(bus_we_o), 32'(0));
    check("rst_sel", 32'(bus_sel_o), 32'(0));
    check("rst_addr", bus_addr_o, 32'h0);
    check("rst_wdata", bus_wdata_o, 32'h0);
    check("rst_inst", inst_rdata_o, 32'h0);
    check("rst_data", data_rdata_o, 32'h0);
    check("rst_stall", 32'(stall_o), 32'(0));
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Fetch only, minimum latency.
    run_txn(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h0000_0004, 0, 0,
            32'h0, 32'h3401_0100);
    // Load + fetch.
    run_txn(1'b1, 1'b0, 4'hF, 32'h0000_0100, 32'h0, 1'b1, 32'h0000_0008, 0, 0,
            32'hDEAD_BEEF, 32'h8C22_0000);
    // Store + fetch: load data must survive.
    run_txn(1'b1, 1'b1, 4'b0011, 32'h0000_0200, 32'h0000_ABCD, 1'b1, 32'h0000_000C, 0, 0,
            32'h5555_AAAA, 32'h2002_0001);
    // Backpressure: three refused request cycles.
    run_txn(1'b1, 1'b0, 4'hF, 32'h0000_0300, 32'h0, 1'b1, 32'h0000_0010, 3, 1,
            32'hCAFE_F00D, 32'h0800_0004);

    // Randomised core cycles and bus latencies.
    for (int t = 0; t < 40; t++) begin
      logic dce;
      logic ice;
      dce = 1'($urandom % 2);
      ice = dce ? 1'($urandom % 2) : 1'b1;
      run_txn(dce, 1'($urandom % 2), 4'($urandom), $urandom, $urandom, ice, $urandom,
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom, $urandom);
    end

    // Idle: no requests, stray data_ok must be ignored.
    data_ce_i = 1'b0;
    inst_ce_i = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("idle10_req", 32'(bus_req_o), 32'(0));
      check("idle10_stall", 32'(stall_o), 32'(0));
      check("idle10_data", data_rdata_o, exp_data);
      check("idle10_inst", inst_rdata_o, exp_inst);
      junk_data_ok();
    end
    @(negedge clk);
    bus_data_ok_i = 1'b0;

    // Reset while a load waits in D_WAIT.
    @(posedge clk);
    #1;
    data_ce_i   = 1'b1;
    data_we_i   = 1'b0;
    data_sel_i  = 4'hF;
    data_addr_i = 32'h0000_0400;
    inst_ce_i   = 1'b1;
    inst_addr_i = 32'h0000_0020;
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_req", 32'(bus_req_o), 32'(1));
    bus_addr_ok_i = 1'b1;
    @(negedge clk);
    bus_addr_ok_i = 1'b0;
    check("dwait_req", 32'(bus_req_o), 32'(0));
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_req", 32'(bus_req_o), 32'(0));
    check("async_rst_data", data_rdata_o, 32'h0);
    check("async_rst_inst", inst_rdata_o, 32'h0);
    exp_data = '0;
    exp_inst = '0;
    data_ce_i = 1'b0;
    inst_ce_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    bus_data_ok_i = 1'b1;
    bus_rdata_i   = 32'h1234_5678;
    @(negedge clk);
    bus_data_ok_i = 1'b0;
    check("stray_data", data_rdata_o, 32'h0);
    check("stray_inst", inst_rdata_o, 32'h0);
    check("stray_req", 32'(bus_req_o), 32'(0));
    check("stray_stall", 32'(stall_o), 32'(0));

    // Bridge still works after the reset.
    @(posedge clk);
    #1;
    run_txn(1'b1, 1'b0, 4'hF, 32'h0000_0500, 32'h0, 1'b1, 32'h0000_0024, 1, 2,
            32'h0BAD_F00D, 32'h1000_FFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu_bus_bridge.md
Name: cpu_bus_bridge

Overview:
- Sits directly below the mips core.
- Consumes the core's instruction-fetch port (rom_*) and data-memory port (ram_*) and serialises both onto one external request/response bus, with at most one transaction outstanding.
- Returns fetched instructions and load data to the core.
- Drives stall_o so the core holds its pipeline until both accesses of the current core cycle have completed.

Parameters:
ADDR_W, 32, address width of core and bus ports
DATA_W, 32, data width; byte-select width is DATA_W/8

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  reset, asynchronous, active-low
inst_ce_i  input  1  core fetch request (core rom_ce_o)
inst_addr_i  input  ADDR_W  fetch address (core rom_addr_o)
inst_rdata_o  output  DATA_W  fetched instruction (to core rom_data_i)
data_ce_i  input  1  core data access request (core ram_ce_o)
data_we_i  input  1  1=store, 0=load
data_sel_i  input  DATA_W/8  byte enables
data_addr_i  input  ADDR_W  data address
data_wdata_i  input  DATA_W  store data
data_rdata_o  output  DATA_W  load data (to core ram_data_i)
stall_o  output  1  1 = core must hold all pipeline registers
bus_req_o  output  1  bus request valid
bus_we_o  output  1  bus write
bus_sel_o  output  DATA_W/8  bus byte enables
bus_addr_o  output  ADDR_W  bus address
bus_wdata_o  output  DATA_W  bus write data
bus_addr_ok_i  input  1  request accepted this cycle
bus_rdata_i  input  DATA_W  read data, valid with bus_data_ok_i
bus_data_ok_i  input  1  response for the outstanding transaction

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; inst_rdata_o=0; data_rdata_o=0; bus_req_o=0; all bus outputs 0.
- FSM states: IDLE, D_REQ, D_WAIT, I_REQ, I_WAIT, DONE.
- IDLE transitions:
  - data_ce_i=1 -> D_REQ.
  - else inst_ce_i=1 -> I_REQ.
  - else stay IDLE.
- D_REQ:
  - bus_req_o=1, bus_we_o=data_we_i, bus_sel_o=data_sel_i, bus_addr_o=data_addr_i, bus_wdata_o=data_wdata_i.
  - On bus_addr_ok_i=1 -> D_WAIT.
- D_WAIT:
  - bus_req_o=0.
  - On bus_data_ok_i=1: if the access is a load, capture data_rdata_o<=bus_rdata_i; a store leaves data_rdata_o unchanged.
  - Then -> I_REQ if inst_ce_i=1, else DONE.
- I_REQ:
  - bus_req_o=1, bus_we_o=0, bus_sel_o=all ones, bus_addr_o=inst_addr_i, bus_wdata_o=0.
  - On bus_addr_ok_i -> I_WAIT.
- I_WAIT: on bus_data_ok_i, inst_rdata_o<=bus_rdata_i -> DONE.
- DONE: lasts exactly 1 cycle; stall_o=0; -> IDLE.
- stall_o is combinational: 1 when state != DONE and (inst_ce_i or data_ce_i); 0 in DONE; 0 in IDLE with no ce.
- Core inputs are stable while stall_o=1; the bridge does not register them.
- Bus outputs stay constant while bus_req_o=1 and bus_addr_ok_i=0. Waiting for addr_ok or data_ok is unbounded.
- Ordering: data access always precedes the fetch in the same core cycle.
- bus_data_ok_i is sampled only in D_WAIT and I_WAIT; it is ignored in every other state.
- bus_addr_ok_i is ignored when bus_req_o=0.
- Minimum latency, with addr_ok in the first REQ cycle and data_ok in the first WAIT cycle:
  - fetch only: IDLE, I_REQ, I_WAIT, DONE = 4 cycles, stall_o high for 3 of them.
  - load + fetch: 6 cycles.
- inst_rdata_o and data_rdata_o hold their last captured value until overwritten.
- Reset mid-transaction: bus_req_o drops immediately and state returns to IDLE. A stale bus_data_ok_i after reset release, while in IDLE, has no effect.

Test Plan:
1. Fetch only: inst_ce_i=1, inst_addr_i=0x00000004, addr_ok in I_REQ, data_ok=1 with rdata=0x34010100 one cycle later -> bus_addr_o=0x00000004, bus_sel_o=4'hF, bus_we_o=0; stall_o 1,1,1,0; inst_rdata_o=0x34010100 in DONE.
2. Load + fetch: data_ce_i=1, data_we_i=0, data_addr_i=0x00000100, sel=4'hF, bus returns 0xDEADBEEF, then fetch returns 0x8C220000 -> first bus request addr 0x100, second addr=inst_addr_i; data_rdata_o=0xDEADBEEF, inst_rdata_o=0x8C220000; stall_o low only in DONE (cycle 6).
3. Store: data_we_i=1, sel=4'b0011, wdata=0x0000ABCD, addr 0x200 -> bus_we_o=1, bus_sel_o=0011, bus_wdata_o=0x0000ABCD; data_rdata_o keeps its prior value; fetch follows.
4. Backpressure: bus_addr_ok_i low for 3 cycles in D_REQ -> bus_req_o and all bus outputs stable for 4 cycles; stall_o stays 1; no state advance.
5. Reset mid D_WAIT: drive rst=0 asynchronously -> bus_req_o=0 and rdata outputs 0 without a clock edge. After release, one stray bus_data_ok_i with rdata=0x12345678 -> data_rdata_o stays 0.
6. Idle: inst_ce_i=data_ce_i=0 for 10 cycles -> bus_req_o=0, stall_o=0, state remains IDLE.
